dlfloat_link_host: RTL and testbench

Host-side link engine for the DLFloat16 MAC tile. It accepts operand pairs on a valid/ready interface and drives them onto the tile's 16-bit input bus as two beats, A then B. It also reassembles the tile's 8-bit result stream (MSB byte, then LSB byte) into 16-bit results, delivered through a result FIFO. It sits in the test/host FPGA fabric, facing the tile's `ui_in`/`uio_in` and `uo_out` pins.

---
 rtl/dlfloat_pkg.sv | 30 +++
 rtl/dlf_sync_fifo.sv | 70 +++++++
 rtl/dlfloat_link_host.sv | 181 ++++++++++++++++++
 tb/tb_dlfloat_link_host.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dlfloat_pkg.sv
// Shared DLFloat16 definitions: field widths, constants, result payload,
// TX beat-slot state enum and a NaN helper.
package dlfloat_pkg;

    localparam int unsigned DLF_W      = 16;
    localparam int unsigned DLF_EXP_W  = 6;
    localparam int unsigned DLF_MANT_W = 9;
    localparam int unsigned DLF_BIAS   = 31;

    localparam logic [DLF_W-1:0] DLF_NAN  = 16'hFFFF;
    localparam logic [DLF_W-1:0] DLF_ZERO = 16'h0000;
    localparam logic [DLF_W-1:0] DLF_ONE  = 16'h3E00;

    // Result as reassembled from the tile byte stream, MSB byte first.
    typedef struct packed {
        logic [7:0] msb;
        logic [7:0] lsb;
    } dlf_result_t;

    // TX beat slot: A operand slot, then B operand slot.
    typedef enum logic {
        IDLE_A = 1'b0,
        IDLE_B = 1'b1
    } tx_state_e;

    function automatic logic dlf_is_nan(input logic [DLF_W-1:0] v);
        return v == DLF_NAN;
    endfunction

endpackage

// File: rtl/dlf_sync_fifo.sv
// Synchronous FIFO with registered storage and occupancy count.
// Ports: clk, rst_n (async active-low), push/din write side, pop/dout read
// side (dout shows the head entry), empty, full, count (0..DEPTH).
// Simultaneous push and pop are both honoured, including when full.
module dlf_sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push;
    logic             do_pop;

    // Status and honoured-operation decode.
    always_comb begin
        empty   = (cnt_q == '0);
        full    = (cnt_q == CNT_W'(DEPTH));
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        dout    = mem_q[rd_q];
        count   = cnt_q;
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= din;
                wr_q        <= wr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

`ifndef SYNTHESIS
    overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full && !pop));
`endif

endmodule

// File: rtl/dlfloat_link_host.sv
// Host-side link engine for the DLFloat16 MAC tile.
// Operand pairs (s_valid/s_ready, s_a, s_b) are driven onto bus_out as an
// A beat then a B beat; bus_phase is 1 while bus_out holds a B beat. Result
// bytes on byte_in (MSB then LSB) are reassembled and delivered through a
// result FIFO on m_valid/m_ready/m_data. Outstanding operations are limited
// to DEPTH credits so the FIFO can never overflow.
// Optional macro DLF_LINK_HOST_STATS_EN adds stat_issued (accepted pairs) and
// stat_nan (pushed results equal to NaN) counter outputs.
module dlfloat_link_host
    import dlfloat_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned RES_LAT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DLF_W-1:0] s_a,
    input  logic [DLF_W-1:0] s_b,
    output logic [DLF_W-1:0] bus_out,
    output logic             bus_phase,
    input  logic [7:0]       byte_in,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DLF_W-1:0] m_data
`ifdef DLF_LINK_HOST_STATS_EN
    ,
    output logic [15:0]      stat_issued,
    output logic [15:0]      stat_nan
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    tx_state_e        state_q;
    logic [DLF_W-1:0] bus_out_q;
    logic [DLF_W-1:0] b_hold_q;
    logic             bus_phase_q;
    logic             a_acc_q;

    logic [RES_LAT-1:0] dl_q;
    logic [RES_LAT-1:0] dl_d;
    logic               lsb_pend_q;
    logic [7:0]         msb_q;
    dlf_result_t        res_q;
    logic               res_vld_q;
    logic [CNT_W-1:0]   inflight_q;
    logic [CNT_W-1:0]   inflight_d;

    logic             accept_c;
    logic             inject_c;
    logic             push_c;
    logic             pop_c;
    logic [DLF_W-1:0] fifo_dout;
    logic             fifo_empty;
    logic             fifo_full;
    logic [CNT_W-1:0] fifo_count;

    // Credit check, handshakes and next values for delay line / inflight.
    always_comb begin
        s_ready  = (state_q == IDLE_A) &&
                   ((SUM_W'(inflight_q) + SUM_W'(fifo_count)) < SUM_W'(DEPTH));
        accept_c = s_valid && s_ready;
        inject_c = (state_q == IDLE_B) && a_acc_q;
        push_c   = res_vld_q;
        pop_c    = m_ready && !fifo_empty;
        dl_d     = (dl_q << 1) | RES_LAT'(inject_c);
        inflight_d = inflight_q;
        if (inject_c && !push_c) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!inject_c && push_c) begin
            inflight_d = inflight_q - CNT_W'(1);
        end
    end

    // TX beat FSM: free-running A/B alternation; idle slots carry zeros.
    // bus_phase tracks the beat now on bus_out, so it follows the slot just left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE_A;
            bus_out_q   <= DLF_ZERO;
            b_hold_q    <= DLF_ZERO;
            bus_phase_q <= 1'b0;
            a_acc_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE_A: begin
                    state_q     <= IDLE_B;
                    bus_phase_q <= 1'b0;
                    a_acc_q     <= accept_c;
                    if (accept_c) begin
                        bus_out_q <= s_a;
                        b_hold_q  <= s_b;
                    end else begin
                        bus_out_q <= DLF_ZERO;
                    end
                end
                IDLE_B: begin
                    state_q     <= IDLE_A;
                    bus_phase_q <= 1'b1;
                    bus_out_q   <= a_acc_q ? b_hold_q : DLF_ZERO;
                end
                default: state_q <= IDLE_A;
            endcase
        end
    end

    // RX: token exit samples MSB, next edge forms the result, next edge pushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_q       <= '0;
            lsb_pend_q <= 1'b0;
            msb_q      <= '0;
            res_q      <= '0;
            res_vld_q  <= 1'b0;
            inflight_q <= '0;
        end else begin
            dl_q       <= dl_d;
            lsb_pend_q <= dl_q[RES_LAT-1];
            if (dl_q[RES_LAT-1]) begin
                msb_q <= byte_in;
            end
            res_vld_q <= lsb_pend_q;
            if (lsb_pend_q) begin
                res_q <= '{msb: msb_q, lsb: byte_in};
            end
            inflight_q <= inflight_d;
        end
    end

    dlf_sync_fifo #(
        .WIDTH (DLF_W),
        .DEPTH (DEPTH)
    ) u_res_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_c),
        .din   (res_q),
        .pop   (pop_c),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign bus_out   = bus_out_q;
    assign bus_phase = bus_phase_q;
    assign m_valid   = !fifo_empty;
    assign m_data    = fifo_dout;

`ifdef DLF_LINK_HOST_STATS_EN
    logic [15:0] stat_issued_q;
    logic [15:0] stat_nan_q;

    // Free-running wrap-around statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued_q <= '0;
            stat_nan_q    <= '0;
        end else begin
            if (accept_c) begin
                stat_issued_q <= stat_issued_q + 16'd1;
            end
            if (push_c && dlf_is_nan(res_q)) begin
                stat_nan_q <= stat_nan_q + 16'd1;
            end
        end
    end

    assign stat_issued = stat_issued_q;
    assign stat_nan    = stat_nan_q;
`endif

`ifndef SYNTHESIS
    credit_a: assert property (@(posedge clk) disable iff (!rst_n)
        (inflight_q <= CNT_W'(DEPTH)) && !(push_c && fifo_full && !pop_c));
`endif

endmodule

// File: tb/tb_dlfloat_link_host.sv
`timescale 1ns/1ps
module tb_dlfloat_link_host;
    import dlfloat_pkg::*;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned RES_LAT = 3;

    logic        clk;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_a;
    logic [15:0] s_b;
    logic [15:0] bus_out;
    logic        bus_phase;
    logic [7:0]  byte_in;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
`ifdef DLF_LINK_HOST_STATS_EN
    logic [15:0] stat_issued;
    logic [15:0] stat_nan;
`endif

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] cur_res;

    typedef struct {
        logic [15:0] data;
        int          t_edge;
    } ev_t;

    ev_t tx_q[$];
    ev_t out_q[$];
    ev_t push_q[$];

    dlfloat_link_host #(
        .DEPTH   (DEPTH),
        .RES_LAT (RES_LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_a         (s_a),
        .s_b         (s_b),
        .bus_out     (bus_out),
        .bus_phase   (bus_phase),
        .byte_in     (byte_in),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data)
`ifdef DLF_LINK_HOST_STATS_EN
        ,
        .stat_issued (stat_issued),
        .stat_nan    (stat_nan)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: edges counted from reset release; odd edges are
    // A slots. Credits = accepted - popped. A pair accepted at edge e has its
    // MSB sampled at e+1+RES_LAT, LSB at e+2+RES_LAT and is visible at e+3+RES_LAT.
    // The model also plays the tile, driving byte_in for the coming edge.
    initial begin : model
        int          n;
        int          accepted;
        int          popped;
        int          nan_cnt;
        int          last_acc;
        logic [15:0] last_a;
        logic [15:0] last_b;
        logic        e_phase;
        logic        e_sready;
        logic        e_mvalid;
        logic [15:0] e_bus;
        ev_t         ev;
        n = 0; accepted = 0; popped = 0; nan_cnt = 0; last_acc = -10;
        last_a = '0; last_b = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                n = 0; accepted = 0; popped = 0; nan_cnt = 0; last_acc = -10;
                tx_q.delete(); out_q.delete(); push_q.delete();
            end
            while (push_q.size() > 0 && push_q[0].t_edge <= n) begin
                if (push_q[0].data == DLF_NAN) nan_cnt++;
                void'(push_q.pop_front());
            end
            e_phase = (n > 0) && (n % 2 == 0);
            if ((n % 2 == 1) && (last_acc == n)) e_bus = last_a;
            else if ((n > 0) && (n % 2 == 0) && (last_acc == n - 1)) e_bus = last_b;
            else e_bus = '0;
            e_sready = (n % 2 == 0) && ((accepted - popped) < int'(DEPTH));
            e_mvalid = (out_q.size() > 0) && (out_q[0].t_edge <= n);

            chk("bus_out", bus_out, e_bus);
            chk("bus_phase", 16'(bus_phase), 16'(e_phase));
            chk("s_ready", 16'(s_ready), 16'(e_sready));
            chk("m_valid", 16'(m_valid), 16'(e_mvalid));
            if (e_mvalid) chk("m_data", m_data, out_q[0].data);
            if (!rst_n) chk("m_data_reset", m_data, 16'h0000);
`ifdef DLF_LINK_HOST_STATS_EN
            chk("stat_issued", stat_issued, 16'(accepted));
            chk("stat_nan", stat_nan, 16'(nan_cnt));
`endif
            byte_in = 8'($urandom);
            if (rst_n) begin
                if (m_ready && e_mvalid) begin
                    void'(out_q.pop_front());
                    popped++;
                end
                if (s_valid && e_sready) begin
                    accepted++;
                    last_acc = n + 1;
                    last_a   = s_a;
                    last_b   = s_b;
                    ev.data   = cur_res;
                    ev.t_edge = n + 2 + int'(RES_LAT);
                    tx_q.push_back(ev);
                    ev.t_edge = n + 4 + int'(RES_LAT);
                    out_q.push_back(ev);
                    push_q.push_back(ev);
                end
                if (tx_q.size() > 0) begin
                    if (tx_q[0].t_edge == n + 1) begin
                        byte_in = tx_q[0].data[15:8];
                    end else if (tx_q[0].t_edge + 1 == n + 1) begin
                        byte_in = tx_q[0].data[7:0];
                        void'(tx_q.pop_front());
                    end
                end
                n++;
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [15:0] r,
                        output int acc_cyc);
        s_a = a; s_b = b; cur_res = r; s_valid = 1'b1;
        acc_cyc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s_ready) begin
                @(posedge clk);
                #1;
                s_valid = 1'b0;
                acc_cyc = cyc;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL send_timeout: s_ready stayed 0 for 200 cycles, required 1");
        s_valid = 1'b0;
    endtask

    task automatic wait_mvalid(output int at);
        at = -1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (m_valid) begin
                at = cyc;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL wait_m_valid: m_valid stayed 0 for 60 cycles, required 1");
    endtask

    task automatic pop_one();
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
    endtask

    initial begin : stim
        int          ta;
        int          tb_b;
        int          tv;
        int          acc[5];
        int          pop_cyc;
        int          prev;
        int          seen;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [15:0] rr;
`ifdef DLF_LINK_HOST_STATS_EN
        logic [15:0] nan0;
        logic [15:0] iss0;
`endif
        rst_n = 1'b0; s_valid = 1'b0; s_a = '0; s_b = '0; m_ready = 1'b0; cur_res = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bus_out", bus_out, 16'h0000);
        chk("rst_bus_phase", 16'(bus_phase), 16'd0);
        chk("rst_m_valid", 16'(m_valid), 16'd0);
        chk("rst_m_data", m_data, 16'h0000);
        chk("rst_s_ready", 16'(s_ready), 16'd1);
        rst_n = 1'b1;

        // Idle: phase alternates starting with the A slot, bus stays zero.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("idle_phase", 16'(bus_phase), 16'(i % 2));
            chk("idle_bus", bus_out, 16'h0000);
        end
        repeat (16) @(posedge clk);
        #1;
        chk("idle_m_valid", 16'(m_valid), 16'd0);

        // Single pair 1.0 x 2.0 with tile result 2.0.
        send(16'h3E00, 16'h4000, 16'h4000, ta);
        chk("a_beat", bus_out, 16'h3E00);
        chk("a_phase", 16'(bus_phase), 16'd0);
        @(posedge clk);
        #1;
        tb_b = cyc;
        chk("b_beat", bus_out, 16'h4000);
        chk("b_phase", 16'(bus_phase), 16'd1);
        wait_mvalid(tv);
        chk("result_latency", 16'(tv - tb_b), 16'(RES_LAT + 2));
        chk("result_data", m_data, 16'h4000);
        pop_one();
        chk("popped_empty", 16'(m_valid), 16'd0);

        // Credit limit with consumer stalled.
        for (int i = 0; i < 4; i++) begin
            send(16'h3E00 + 16'(i), 16'h4000 + 16'(i), 16'h1111 * 16'(i + 1), acc[i]);
            if (i > 0) chk("credit_gap", 16'(acc[i] - acc[i-1]), 16'd2);
        end
        fork
            send(16'h4200, 16'h4200, 16'h4400, acc[4]);
            begin
                repeat (20) @(posedge clk);
                #1;
                chk("held_s_ready_0", 16'(s_ready), 16'd0);
                chk("held_m_valid", 16'(m_valid), 16'd1);
                @(posedge clk);
                #1;
                chk("held_s_ready_1", 16'(s_ready), 16'd0);
                m_ready = 1'b1;
                @(posedge clk);
                pop_cyc = cyc + 1;
                #1;
                m_ready = 1'b0;
            end
        join
        chk("reaccept_after_pop", 16'((acc[4] > pop_cyc) && (acc[4] - pop_cyc <= 2)), 16'd1);
        m_ready = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("drained", 16'(m_valid), 16'd0);

        // Back-to-back stream with consumer always ready.
        prev = 0;
        for (int i = 0; i < 8; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rr = 16'($urandom);
            send(ra, rb, rr, ta);
            if (i > 0) chk("b2b_gap", 16'(ta - prev), 16'd2);
            prev = ta;
        end
        repeat (30) @(posedge clk);
        #1;
        chk("b2b_drained", 16'(m_valid), 16'd0);

        // NaN result.
        m_ready = 1'b0;
`ifdef DLF_LINK_HOST_STATS_EN
        nan0 = stat_nan;
        iss0 = stat_issued;
`endif
        send(16'h7E00, 16'hFFFF, DLF_NAN, ta);
        wait_mvalid(tv);
        chk("nan_data", m_data, 16'hFFFF);
`ifdef DLF_LINK_HOST_STATS_EN
        chk("nan_stat_delta", stat_nan - nan0, 16'd1);
        chk("issued_stat_delta", stat_issued - iss0, 16'd1);
`endif
        pop_one();

        // Reset with one result queued and two tokens in flight.
        send(16'h3E00, 16'h3E00, 16'h3E00, ta);
        wait_mvalid(tv);
        send(16'h4000, 16'h3E00, 16'h4000, ta);
        send(16'h4000, 16'h4000, 16'h4100, ta);
        @(posedge clk);
        #1;
        chk("pre_reset_m_valid", 16'(m_valid), 16'd1);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("post_reset_s_ready", 16'(s_ready), 16'd1);
`ifdef DLF_LINK_HOST_STATS_EN
        chk("post_reset_issued", stat_issued, 16'd0);
        chk("post_reset_nan", stat_nan, 16'd0);
`endif
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (m_valid) seen++;
        end
        chk("post_reset_no_result", 16'(seen), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
